dcache_write_buffer: RTL and testbench

DCACHE_WRITE_BUFFER -- requirements
Module: dcache_write_buffer

---
 rtl/dcache_write_buffer.sv | 113 +++++++++++
 tb/tb_dcache_write_buffer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_write_buffer.sv
// Single-entry write buffer between dcache and arbiter; optional read forwarding under WBUF_FORWARD_EN.
// Latency: buffered write acked 1 cycle after capture; reads cost one arbiter round trip (or 2 cycles when forwarded).
// Backpressure: dcache holds mem_read/mem_write until mem_resp; arb_* outputs are held until arb_resp.
module dcache_write_buffer (
  input  logic         clk,
  input  logic         reset,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [15:0]  mem_address,
  input  logic [127:0] mem_wdata,
  output logic [127:0] mem_rdata,
  output logic         mem_resp,
  output logic         arb_read,
  output logic         arb_write,
  output logic [15:0]  arb_address,
  output logic [127:0] arb_wdata,
  input  logic         arb_resp,
  input  logic [127:0] arb_rdata
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]   state;
  logic         valid;
  logic [15:0]  addr;
  logic [15:0]  raddr;
  logic [127:0] data;
  logic         blk_match;

  assign blk_match = valid && (addr[15:4] == mem_address[15:4]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      valid     <= 1'b0;
      addr      <= '0;
      raddr     <= '0;
      data      <= '0;
      mem_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_read) begin
`ifdef WBUF_FORWARD_EN
            if (blk_match) begin
              mem_rdata <= data;
              state     <= RESP;
            end else begin
              raddr <= mem_address;
              state <= READ;
            end
`else
            // Same-block read must see the buffered data in memory first.
            if (blk_match) begin
              state <= DRAIN;
            end else begin
              raddr <= mem_address;
              state <= READ;
            end
`endif
          end else if (mem_write && !valid) begin
            addr  <= mem_address;
            data  <= mem_wdata;
            valid <= 1'b1;
            state <= RESP;
          end else if (valid) begin
            state <= DRAIN;
          end
        end
        READ: begin
          if (arb_resp) begin
            mem_rdata <= arb_rdata;
            state     <= RESP;
          end
        end
        DRAIN: begin
          if (arb_resp) begin
            valid <= 1'b0;
            state <= IDLE;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are pure decodes of state and registers, so they hold steady while waiting.
  always_comb begin
    mem_resp    = 1'b0;
    arb_read    = 1'b0;
    arb_write   = 1'b0;
    arb_address = '0;
    arb_wdata   = '0;
    case (state)
      READ: begin
        arb_read    = 1'b1;
        arb_address = raddr;
      end
      DRAIN: begin
        arb_write   = 1'b1;
        arb_address = addr;
        arb_wdata   = data;
      end
      RESP:    mem_resp = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dcache_write_buffer.sv
// Directed bench for dcache_write_buffer with a small arbiter/memory model; honours WBUF_FORWARD_EN.
module tb_dcache_write_buffer;

  logic         clk = 1'b0;
  logic         reset;
  logic         mem_read;
  logic         mem_write;
  logic [15:0]  mem_address;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_resp;
  logic         arb_read;
  logic         arb_write;
  logic [15:0]  arb_address;
  logic [127:0] arb_wdata;
  logic         arb_resp;
  logic [127:0] arb_rdata;

  localparam logic [127:0] D0 = 128'h0123_4567_89ab_cdef_0011_2233_4455_6677;
  localparam logic [127:0] D2 = 128'hdead_beef_cafe_f00d_1357_9bdf_2468_ace0;
  localparam logic [127:0] D3 = 128'h3333_0000_3333_1111_3333_2222_3333_4444;
  localparam logic [127:0] D5 = 128'h5555_aaaa_5555_aaaa_5555_aaaa_5555_aaaa;

  int n_chk  = 0;
  int n_pass = 0;

  // Arbiter transaction log and backing memory, keyed by block number.
  logic         log_w [32];
  logic [15:0]  log_a [32];
  logic [127:0] log_d [32];
  int           log_n = 0;
  logic         both_seen = 1'b0;
  logic [127:0] mem [int];

  dcache_write_buffer dut (
    .clk         (clk),
    .reset       (reset),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_resp    (mem_resp),
    .arb_read    (arb_read),
    .arb_write   (arb_write),
    .arb_address (arb_address),
    .arb_wdata   (arb_wdata),
    .arb_resp    (arb_resp),
    .arb_rdata   (arb_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] pat(input logic [15:0] a);
    return {4{a[15:4], 4'h0, 16'hc0de}};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic do_req(input string tag, input logic rd, input logic wr, input logic [15:0] a,
                        input logic [127:0] wd, output int cyc, output logic [127:0] rdat);
    mem_read    = rd;
    mem_write   = wr;
    mem_address = a;
    mem_wdata   = wd;
    cyc = 0;
    do begin
      tick;
      cyc++;
    end while (!mem_resp && cyc < 200);
    chk(tag, mem_resp, 1'b1);
    rdat = mem_rdata;
  endtask

  task automatic idle_in;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic wait_log(input string tag, input int n);
    int k = 0;
    while (log_n < n && k < 200) begin
      tick;
      k++;
    end
    chk(tag, log_n, n);
    tick;
    tick;
  endtask

  // Arbiter: responds on the third cycle a request is seen, resets with the DUT.
  initial begin
    int cnt = 0;
    arb_resp  = 1'b0;
    arb_rdata = '0;
    forever begin
      @(negedge clk);
      if (arb_read && arb_write) both_seen = 1'b1;
      if (reset) begin
        arb_resp = 1'b0;
        cnt = 0;
      end else if (arb_resp) begin
        arb_resp = 1'b0;
        cnt = 0;
      end else if (arb_read || arb_write) begin
        if (cnt == 2) begin
          arb_resp = 1'b1;
          log_w[log_n] = arb_write;
          log_a[log_n] = arb_address;
          if (arb_write) begin
            mem[int'(arb_address[15:4])] = arb_wdata;
            log_d[log_n] = arb_wdata;
          end else begin
            arb_rdata = mem.exists(int'(arb_address[15:4])) ? mem[int'(arb_address[15:4])]
                                                            : pat(arb_address);
            log_d[log_n] = arb_rdata;
          end
          if (log_n < 31) log_n++;
        end else begin
          cnt++;
        end
      end
    end
  end

  initial begin
    int cyc;
    int b;
    int k;
    logic [127:0] rd;

    reset = 1'b1;
    idle_in;
    mem_address = '0;
    mem_wdata   = '0;
    #2;
    chk("rst_mem_resp", mem_resp, 1'b0);
    chk("rst_arb_read", arb_read, 1'b0);
    chk("rst_arb_write", arb_write, 1'b0);
    chk("rst_mem_rdata", mem_rdata, '0);
    chk("rst_arb_address", arb_address, '0);
    chk("rst_arb_wdata", arb_wdata, '0);
    tick;
    reset = 1'b0;

    // Write to empty buffer is acked at once, then drained.
    b = log_n;
    do_req("w1_resp", 1'b0, 1'b1, 16'h1230, D0, cyc, rd);
    chk("w1_latency", cyc, 1);
    idle_in;
    tick;
    chk("w1_resp_one_pulse", mem_resp, 1'b0);
    k = 0;
    while (!arb_write && k < 50) begin
      tick;
      k++;
    end
    chk("w1_arb_write", arb_write, 1'b1);
    chk("w1_arb_read_low", arb_read, 1'b0);
    chk("w1_arb_address", arb_address, 16'h1230);
    chk("w1_arb_wdata", arb_wdata, D0);
    wait_log("w1_drain_done", b + 1);
    chk("w1_arb_write_cleared", arb_write, 1'b0);
    chk("w1_no_redrain", log_n, b + 1);

    // Read to a different block bypasses the buffered write.
    b = log_n;
    do_req("byp_wresp", 1'b0, 1'b1, 16'h1230, D0, cyc, rd);
    do_req("byp_rresp", 1'b1, 1'b0, 16'h4560, '0, cyc, rd);
    chk("byp_rdata", rd, pat(16'h4560));
    idle_in;
    wait_log("byp_log", b + 2);
    chk("byp_first_is_read", log_w[b], 1'b0);
    chk("byp_read_addr", log_a[b], 16'h4560);
    chk("byp_then_write", log_w[b + 1], 1'b1);
    chk("byp_write_addr", log_a[b + 1], 16'h1230);
    chk("byp_write_data", log_d[b + 1], D0);

    // Same-block read: forwarded or drained-then-read depending on build.
    b = log_n;
    do_req("fw_wresp", 1'b0, 1'b1, 16'h1230, D0, cyc, rd);
    do_req("fw_rresp", 1'b1, 1'b0, 16'h1238, '0, cyc, rd);
    chk("fw_rdata", rd, D0);
`ifdef WBUF_FORWARD_EN
    chk("fw_latency", cyc, 2);
    chk("fw_no_arb_at_resp", log_n, b);
    idle_in;
    wait_log("fw_drain", b + 1);
    chk("fw_only_drain_write", log_w[b], 1'b1);
    chk("fw_drain_addr", log_a[b], 16'h1230);
    tick;
    chk("fw_no_arb_read", log_n, b + 1);
`else
    idle_in;
    wait_log("nofw_log", b + 2);
    chk("nofw_drain_first", log_w[b], 1'b1);
    chk("nofw_drain_addr", log_a[b], 16'h1230);
    chk("nofw_then_read", log_w[b + 1], 1'b0);
    chk("nofw_read_addr", log_a[b + 1], 16'h1238);
`endif

    // Write while full waits for the drain before being accepted.
    b = log_n;
    do_req("full_w1resp", 1'b0, 1'b1, 16'h1230, D0, cyc, rd);
    do_req("full_w2resp", 1'b0, 1'b1, 16'h2000, D2, cyc, rd);
    chk("full_drained_before_ack", log_n, b + 1);
    chk("full_drain_addr", log_a[b], 16'h1230);
    idle_in;
    wait_log("full_log", b + 2);
    chk("full_w2_is_write", log_w[b + 1], 1'b1);
    chk("full_w2_addr", log_a[b + 1], 16'h2000);
    chk("full_w2_data", log_d[b + 1], D2);

    // Read and write together: read goes first, write only after read ack.
    b = log_n;
    do_req("both_rresp", 1'b1, 1'b1, 16'h3000, D3, cyc, rd);
    chk("both_rdata", rd, pat(16'h3000));
    chk("both_only_read", log_n, b + 1);
    chk("both_read_kind", log_w[b], 1'b0);
    chk("both_read_addr", log_a[b], 16'h3000);
    do_req("both_wresp", 1'b0, 1'b1, 16'h4000, D3, cyc, rd);
    chk("both_w_latency", cyc, 2);
    idle_in;
    wait_log("both_log", b + 2);
    chk("both_w_addr", log_a[b + 1], 16'h4000);
    chk("both_w_data", log_d[b + 1], D3);

    // Reset during a drain drops the buffered block.
    do_req("rst_wresp", 1'b0, 1'b1, 16'h1230, D5, cyc, rd);
    idle_in;
    k = 0;
    while (!arb_write && k < 50) begin
      tick;
      k++;
    end
    chk("rst_drain_started", arb_write, 1'b1);
    reset = 1'b1;
    #1;
    chk("rst_mid_arb_write", arb_write, 1'b0);
    chk("rst_mid_mem_resp", mem_resp, 1'b0);
    chk("rst_mid_arb_address", arb_address, '0);
    tick;
    reset = 1'b0;
    b = log_n;
    do_req("rst_rresp", 1'b1, 1'b0, 16'h1230, '0, cyc, rd);
    chk("rst_read_from_mem", rd, D0);
    idle_in;
    tick;
    tick;
    tick;
    chk("rst_single_arb_txn", log_n, b + 1);
    chk("rst_arb_read_kind", log_w[b], 1'b0);
    chk("rst_arb_read_addr", log_a[b], 16'h1230);

    chk("arb_rd_wr_exclusive", both_seen, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
